// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Shares one combinational ALU between two requesters. A request is
//   accepted in IDLE, its operands are held on the alu_* outputs, the ALU
//   result is registered at the end of EXEC, and RESP presents it to the
//   owning requester until that requester takes it.
//
// Configuration macro:
//   ALU_ARB_RR_EN  defined   -> round-robin between requesters when both
//                               are valid (the one not served last wins)
//                  undefined -> fixed priority, requester 0 always wins
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req_valid/req_ready per-requester request handshake (bit i = requester i)
//   reqN_A/B/ALUFun/Sign operands and function code from requester N
//   alu_A/B/ALUFun/Sign operands driven to the shared ALU (held registers)
//   alu_Z               combinational result returned by the shared ALU
//   rsp_valid/rsp_ready per-requester response handshake
//   rsp_Z               registered ALU result
//   busy                high whenever an operation is in flight
//   grant_id            requester owning the current/last operation
module alu_arbiter #(
  parameter int DW = 32,
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req0_A,
  input  logic [DW-1:0] req1_A,
  input  logic [DW-1:0] req0_B,
  input  logic [DW-1:0] req1_B,
  input  logic [FW-1:0] req0_ALUFun,
  input  logic [FW-1:0] req1_ALUFun,
  input  logic          req0_Sign,
  input  logic          req1_Sign,
  output logic [DW-1:0] alu_A,
  output logic [DW-1:0] alu_B,
  output logic [FW-1:0] alu_ALUFun,
  output logic          alu_Sign,
  input  logic [DW-1:0] alu_Z,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_Z,
  output logic          busy,
  output logic          grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic            sel;
  logic            accept;

  logic [DW-1:0]   a_p0;
  logic [DW-1:0]   b_p0;
  logic [FW-1:0]   fun_p0;
  logic            sign_p0;
  logic            grant_p0;
  logic [DW-1:0]   z_p1;

`ifdef ALU_ARB_RR_EN
  logic            last_p0;

  // Both valid: the requester not served last wins; a lone request always wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      sel = ~last_p0;
    end else begin
      sel = req_valid[1] & ~req_valid[0];
    end
  end
`else
  // Requester 0 wins whenever it is valid.
  always_comb begin
    sel = ~req_valid[0];
  end
`endif

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = sel ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = grant_p0 ? 2'b10 : 2'b01;
        // Only the owning requester's rsp_ready can release the result.
        if (rsp_ready[grant_p0]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_p0     <= '0;
      b_p0     <= '0;
      fun_p0   <= '0;
      sign_p0  <= 1'b0;
      grant_p0 <= 1'b0;
      z_p1     <= '0;
`ifdef ALU_ARB_RR_EN
      last_p0  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      // Stage p0: operands of the accepted request, held until the next accept.
      if (accept) begin
        a_p0     <= sel ? req1_A      : req0_A;
        b_p0     <= sel ? req1_B      : req0_B;
        fun_p0   <= sel ? req1_ALUFun : req0_ALUFun;
        sign_p0  <= sel ? req1_Sign   : req0_Sign;
        grant_p0 <= sel;
`ifdef ALU_ARB_RR_EN
        last_p0  <= sel;
`endif
      end
      // Stage p1: ALU result captured at the end of EXEC, held through RESP.
      if (state_q == EXEC) begin
        z_p1 <= alu_Z;
      end
    end
  end

  assign alu_A      = a_p0;
  assign alu_B      = b_p0;
  assign alu_ALUFun = fun_p0;
  assign alu_Sign   = sign_p0;
  assign rsp_Z      = z_p1;
  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_p0;

endmodule
